// File: rtl/dmem_port_responder_if.sv
// Data-memory port between the WB/MEM stage (master) and the memory responder (slave).
// Four-phase level handshake: enable held until done, then dropped.
interface dmem_port_responder_if;
  logic        enable;
  logic        write_read;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        done;
  logic        err;

  modport master (
    output enable, write_read, mem_ctrl, addr, data_in,
    input  data_out, done, err
  );

  modport slave (
    input  enable, write_read, mem_ctrl, addr, data_in,
    output data_out, done, err
  );
endinterface

// File: rtl/dmem_port_responder.sv
// Memory-side responder for the core's data port: one RV32 byte/half/word access
// at a time against a word-organised array, completing after LATENCY cycles.

module dmem_byte_lane #(
  parameter logic [1:0] LANE = 2'd0
) (
  input  logic [1:0] size,
  input  logic [1:0] ofs,
  output logic       be
);
  always_comb begin
    be = 1'b0;
    case (size)
      2'b00:   be = (ofs == LANE);
      2'b01:   be = (ofs[1] == LANE[1]);
      2'b10:   be = 1'b1;
      default: be = 1'b0;
    endcase
  end
endmodule

module dmem_port_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_responder_if.slave  bus
);
  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] dout_q, dout_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0]        idx;
  logic [1:0]           ofs;
  logic                 oor, misalign, illegal, bad;
  logic [31:0]          rd_word, ld_data, wrep;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic [NUM_LANES-1:0] be;
  logic                 mem_we;

  assign idx = req_q.addr[AW+1:2];
  assign ofs = req_q.addr[1:0];
  assign oor = |req_q.addr[31:AW+2];

  always_comb begin
    illegal = 1'b1;
    case (req_q.ctrl)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_q.wr;
      default:                illegal = 1'b1;
    endcase
  end

  assign misalign = ((req_q.ctrl[1:0] == 2'b01) & ofs[0]) |
                    ((req_q.ctrl[1:0] == 2'b10) & (|ofs));
  assign bad      = oor | misalign | illegal;

  // Replicate the store data across lanes so each lane just takes its own byte.
  always_comb begin
    wrep = req_q.wdata;
    case (req_q.ctrl[1:0])
      2'b00:   wrep = {4{req_q.wdata[7:0]}};
      2'b01:   wrep = {2{req_q.wdata[15:0]}};
      default: wrep = req_q.wdata;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_byte_lane #(.LANE(2'(i))) u_lane (
      .size (req_q.ctrl[1:0]),
      .ofs  (ofs),
      .be   (be[i])
    );
  end

  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{ofs, 3'b000} +: 8];
  assign rd_half = rd_word[{ofs[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = '0;
    case (req_q.ctrl)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    dout_d  = dout_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          req_d   = '{wr: bus.write_read, ctrl: bus.mem_ctrl,
                      addr: bus.addr, wdata: bus.data_in};
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = req_q.wr & ~bad;
          dout_d  = (bad | req_q.wr) ? 32'd0 : ld_data;
          err_d   = bad;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Storage is deliberately unreset; a reset mid-WAIT forces IDLE so no write fires.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_dmem_port_responder.sv
// Bench for dmem_port_responder: directed RV32 access cases plus randomized
// traffic against a byte-addressed reference memory.
module tb_dmem_port_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  dmem_port_responder_if bus ();

  dmem_port_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mmem [logic [31:0]];

  // Reference: RV32 load/store semantics on a byte-addressed memory.
  function automatic void model(input logic wr, input logic [2:0] ctrl,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] r, output logic e);
    int n;
    logic legal;
    logic [31:0] v, mask;
    legal = wr ? (ctrl inside {3'd0, 3'd1, 3'd2}) : (ctrl inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    n = 1 << ctrl[1:0];
    e = !legal || ((a % n) != 0) || (a >= 32'(DEPTH * 4));
    r = 32'd0;
    if (!e && wr) begin
      for (int i = 0; i < n; i++) mmem[a + i] = d[8*i +: 8];
    end else if (!e) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mmem[a + i]) << (8 * i));
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      if (!ctrl[2] && n < 4 && v[8*n-1]) v = v | ~mask;
      r = v;
    end
  endfunction

  task automatic access(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] dout, output logic e,
                        output int lat, output logic dclr);
    @(negedge clk);
    bus.enable = 1'b1; bus.write_read = wr; bus.mem_ctrl = ctrl;
    bus.addr = a; bus.data_in = d;
    @(posedge clk);
    @(negedge clk);
    bus.write_read = 1'($urandom); bus.mem_ctrl = 3'($urandom);
    bus.addr = $urandom; bus.data_in = $urandom;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.done && lat < 40);
    dout = bus.data_out; e = bus.err;
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    dclr = !bus.done;
  endtask

  task automatic run(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] dout, output logic e,
                     output logic [31:0] xd, output logic xe, output int lat, output logic dclr);
    model(wr, ctrl, a, d, xd, xe);
    access(wr, ctrl, a, d, dout, e, lat, dclr);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0; bus.write_read = 1'b0; bus.mem_ctrl = 3'd0;
    bus.addr = '0; bus.data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.done, bus.err, bus.data_out} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b err=%b dout=%h want 0/0/0", bus.done, bus.err, bus.data_out);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: done=%b want 0", bus.done);
    end
  endtask

  task automatic test_plan();
    logic [31:0] dout, xd; logic e, xe, dclr; int lat;
    logic [2:0]  c [9]  = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd4, 3'd2, 3'd1, 3'd2, 3'd1};
    logic        w [9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ad [9] = '{32'h10, 32'h10, 32'h11, 32'h11, 32'h11, 32'h10, 32'h12, 32'h10, 32'h12};
    logic [31:0] dd [9] = '{32'hDEADBEEF, 0, 32'h80, 0, 0, 0, 32'h1234ABCD, 0, 0};
    logic [31:0] ex [9] = '{0, 32'hDEADBEEF, 0, 32'hFFFFFF80, 32'h00000080, 32'hDEAD80EF,
                            0, 32'hABCD80EF, 32'hFFFFABCD};
    for (int i = 0; i < 9; i++) begin
      run(w[i], c[i], ad[i], dd[i], dout, e, xd, xe, lat, dclr);
      n_chk++;
      if (dout !== ex[i] || e !== 1'b0) begin
        n_fail++; $display("FAIL plan_%0d: got dout=%h err=%b want %h/0", i, dout, e, ex[i]);
      end
      n_chk++;
      if (lat !== LATENCY || !dclr) begin
        n_fail++; $display("FAIL plan_timing_%0d: latency %0d cleared %b want %0d/1", i, lat, dclr, LATENCY);
      end
    end
    run(1'b0, 3'd5, 32'h12, 0, dout, e, xd, xe, lat, dclr);
    n_chk++;
    if (dout !== 32'h0000ABCD) begin
      n_fail++; $display("FAIL plan_lhu: got %h want 0000abcd", dout);
    end
  endtask

  task automatic test_init();
    logic [31:0] dout, xd; logic e, xe, dclr; int lat;
    for (int i = 0; i < 64; i++) begin
      if (i == 4) continue;
      run(1'b1, 3'd2, 32'(i * 4), $urandom, dout, e, xd, xe, lat, dclr);
    end
  endtask

  task automatic test_errors();
    logic [31:0] dout, xd; logic e, xe, dclr; int lat;
    logic        w [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  c [6]  = '{3'd2, 3'd1, 3'd2, 3'd3, 3'd2, 3'd4};
    logic [31:0] ad [6] = '{32'h13, 32'h11, 32'h8000_0010, 32'h10, 32'h1000, 32'h10};
    for (int i = 0; i < 6; i++) begin
      run(w[i], c[i], ad[i], 32'hFFFF_FFFF, dout, e, xd, xe, lat, dclr);
      n_chk++;
      if (e !== 1'b1 || dout !== 32'd0) begin
        n_fail++; $display("FAIL err_%0d: got err=%b dout=%h want 1/0", i, e, dout);
      end
    end
    run(1'b0, 3'd2, 32'h10, 0, dout, e, xd, xe, lat, dclr);
    n_chk++;
    if (dout !== 32'hABCD80EF || e !== 1'b0) begin
      n_fail++; $display("FAIL err_nowrite: got %h err=%b want abcd80ef/0", dout, e);
    end
    run(1'b1, 3'd2, 32'hFFC, 32'hCAFEF00D, dout, e, xd, xe, lat, dclr);
    run(1'b0, 3'd2, 32'hFFC, 0, dout, e, xd, xe, lat, dclr);
    n_chk++;
    if (dout !== 32'hCAFEF00D || e !== 1'b0) begin
      n_fail++; $display("FAIL last_word: got %h err=%b want cafef00d/0", dout, e);
    end
  endtask

  task automatic test_hold();
    logic [31:0] xd, dout; logic xe, e, dclr; int lat;
    model(1'b0, 3'd2, 32'h10, 0, xd, xe);
    @(negedge clk);
    bus.enable = 1'b1; bus.write_read = 1'b0; bus.mem_ctrl = 3'd2; bus.addr = 32'h10;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.done && lat < 40);
    n_chk++;
    if (lat !== LATENCY + 1) begin
      n_fail++; $display("FAIL hold_latency: got %0d edges want %0d", lat, LATENCY + 1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.write_read = 1'b1; bus.mem_ctrl = 3'd2; bus.addr = 32'h40; bus.data_in = $urandom;
      @(posedge clk); #1;
      n_chk++;
      if (bus.done !== 1'b1 || bus.data_out !== xd) begin
        n_fail++; $display("FAIL hold_%0d: done=%b dout=%h want 1/%h", k, bus.done, bus.data_out, xd);
      end
    end
    @(negedge clk); bus.enable = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL hold_release: done=%b want 0", bus.done);
    end
    run(1'b0, 3'd2, 32'h40, 0, dout, e, xd, xe, lat, dclr);
    n_chk++;
    if (dout !== xd) begin
      n_fail++; $display("FAIL hold_no_second_access: got %h want %h", dout, xd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] dout, xd; logic e, xe, dclr; int lat;
    run(1'b1, 3'd2, 32'h20, 32'h11111111, dout, e, xd, xe, lat, dclr);
    run(1'b0, 3'd2, 32'h20, 0, dout, e, xd, xe, lat, dclr);
    @(negedge clk);
    bus.enable = 1'b1; bus.write_read = 1'b1; bus.mem_ctrl = 3'd2;
    bus.addr = 32'h20; bus.data_in = 32'h55;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.done, bus.err, bus.data_out} !== 34'd0) begin
      n_fail++; $display("FAIL reset_mid: done=%b err=%b dout=%h want 0/0/0", bus.done, bus.err, bus.data_out);
    end
    bus.enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    run(1'b0, 3'd2, 32'h20, 0, dout, e, xd, xe, lat, dclr);
    n_chk++;
    if (dout !== 32'h11111111 || lat !== LATENCY) begin
      n_fail++; $display("FAIL reset_drop_store: got %h lat %0d want 11111111 lat %0d", dout, lat, LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dout, xd, a, d; logic e, xe, dclr; int lat;
    for (int i = 0; i < 10; i++) begin
      a = 32'($urandom_range(0, 63)) << 2;
      d = $urandom;
      run(1'b1, 3'd2, a, d, dout, e, xd, xe, lat, dclr);
      run(1'b0, 3'd2, a, 0, dout, e, xd, xe, lat, dclr);
      n_chk++;
      if (dout !== d) begin
        n_fail++; $display("FAIL raw_%0d: addr %h got %h want %h", i, a, dout, d);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] dout, xd, a; logic e, xe, dclr, w; logic [2:0] c; int lat;
    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom);
      c = 3'($urandom);
      a = 32'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0: a = a | 32'h8000_0000;
        1: a = a + 32'(DEPTH * 4);
        default: ;
      endcase
      run(w, c, a, $urandom, dout, e, xd, xe, lat, dclr);
      n_chk++;
      if (dout !== xd || e !== xe || lat !== LATENCY || !dclr) begin
        n_fail++;
        $display("FAIL rand_%0d: wr=%b ctrl=%b addr=%h got %h/%b lat %0d clr %b want %h/%b lat %0d clr 1",
                 i, w, c, a, dout, e, lat, dclr, xd, xe, LATENCY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_init();
    test_errors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
